// File: rtl/writeback_unit_if.sv
// Writeback unit bus: memory-stage result stream, load response and
// register-file write port grouped into one bundle.
interface writeback_unit_if;
    logic        in_valid;
    logic        in_ready;
    logic        in_wen;
    logic [4:0]  in_rd;
    logic        in_is_load;
    logic [2:0]  in_funct3;
    logic [1:0]  in_addr_lo;
    logic [31:0] in_result;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        wen;
    logic [4:0]  addrW;
    logic [31:0] dataW;
    logic        stall;
    logic        load_err;
    logic [31:0] retired;

    modport master (
        output in_valid, in_wen, in_rd, in_is_load,
        output in_funct3, in_addr_lo, in_result,
        output mem_rvalid, mem_rdata,
        input  in_ready, wen, addrW, dataW,
        input  stall, load_err, retired
    );

    modport slave (
        input  in_valid, in_wen, in_rd, in_is_load,
        input  in_funct3, in_addr_lo, in_result,
        input  mem_rvalid, mem_rdata,
        output in_ready, wen, addrW, dataW,
        output stall, load_err, retired
    );
endinterface

// File: rtl/writeback_unit.sv
// Writeback stage: commits ALU results directly and waits for load
// data (with alignment, extension and a response timeout).
module writeback_unit #(
    parameter int TIMEOUT = 16
) (
    input logic             clk,
    input logic             rst_n,
    writeback_unit_if.slave bus
);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_MEM = 1'b1
    } state_e;

    state_e        state_q;
    logic          wen_q;
    logic [4:0]    addr_q;
    logic [31:0]   data_q;
    logic          err_q;
    logic [31:0]   ret_q;
    logic [CW-1:0] cnt_q;
    logic          ld_wen_q;
    logic [4:0]    ld_rd_q;
    logic [2:0]    ld_f3_q;
    logic [1:0]    ld_lo_q;

    logic [7:0]    byte_d;
    logic [15:0]   half_d;
    logic [31:0]   align_d;

    assign bus.in_ready = (state_q == IDLE);
    assign bus.stall    = (state_q == WAIT_MEM);
    assign bus.wen      = wen_q;
    assign bus.addrW    = addr_q;
    assign bus.dataW    = data_q;
    assign bus.load_err = err_q;
    assign bus.retired  = ret_q;

    // Select and extend the addressed byte/halfword of the load word.
    always_comb begin
        byte_d  = bus.mem_rdata[{ld_lo_q, 3'b000} +: 8];
        half_d  = ld_lo_q[1] ? bus.mem_rdata[31:16]
                             : bus.mem_rdata[15:0];
        align_d = bus.mem_rdata;
        case (ld_f3_q)
            3'b000:  align_d = {{24{byte_d[7]}}, byte_d};
            3'b100:  align_d = {24'd0, byte_d};
            3'b001:  align_d = {{16{half_d[15]}}, half_d};
            3'b101:  align_d = {16'd0, half_d};
            default: align_d = bus.mem_rdata;
        endcase
    end

    // Control FSM with registered write port, error pulse and counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            wen_q    <= 1'b0;
            addr_q   <= 5'd0;
            data_q   <= 32'd0;
            err_q    <= 1'b0;
            ret_q    <= 32'd0;
            cnt_q    <= '0;
            ld_wen_q <= 1'b0;
            ld_rd_q  <= 5'd0;
            ld_f3_q  <= 3'd0;
            ld_lo_q  <= 2'd0;
        end else begin
            wen_q <= 1'b0;
            err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        if (bus.in_is_load) begin
                            ld_wen_q <= bus.in_wen;
                            ld_rd_q  <= bus.in_rd;
                            ld_f3_q  <= bus.in_funct3;
                            ld_lo_q  <= bus.in_addr_lo;
                            cnt_q    <= '0;
                            state_q  <= WAIT_MEM;
                        end else begin
                            wen_q  <= bus.in_wen && (bus.in_rd != 5'd0);
                            addr_q <= bus.in_rd;
                            data_q <= bus.in_result;
                            ret_q  <= ret_q + 32'd1;
                        end
                    end
                end
                WAIT_MEM: begin
                    if (bus.mem_rvalid) begin
                        wen_q   <= ld_wen_q && (ld_rd_q != 5'd0);
                        addr_q  <= ld_rd_q;
                        data_q  <= align_d;
                        ret_q   <= ret_q + 32'd1;
                        state_q <= IDLE;
                    end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                        err_q   <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_writeback_unit.sv
// Bench for writeback_unit: scoreboard of expected register writes
// plus per-scenario checks of handshake, timeout and reset behaviour.
module tb_writeback_unit;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    writeback_unit_if bus();

    writeback_unit #(.TIMEOUT(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [36:0] exp_q[$];
    logic [36:0] mon_e;
    logic [31:0] ret_exp = 32'd0;

    // Scoreboard: every write seen must match the oldest expected one.
    always @(negedge clk) begin
        if (rst_n && bus.wen === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL write_unexpected: got rd=%0d data=%h, required no write",
                         bus.addrW, bus.dataW);
            end else begin
                mon_e = exp_q.pop_front();
                if ({bus.addrW, bus.dataW} !== mon_e) begin
                    errors++;
                    $display("FAIL write_value: got rd=%0d data=%h, required rd=%0d data=%h",
                             bus.addrW, bus.dataW, mon_e[36:32], mon_e[31:0]);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.in_valid   = 1'b0;
        bus.in_wen     = 1'b0;
        bus.in_rd      = 5'd0;
        bus.in_is_load = 1'b0;
        bus.in_funct3  = 3'd0;
        bus.in_addr_lo = 2'd0;
        bus.in_result  = 32'd0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 32'd0;
    endtask

    task automatic send_alu(input logic w, input logic [4:0] rd,
                            input logic [31:0] res);
        bus.in_valid   = 1'b1;
        bus.in_is_load = 1'b0;
        bus.in_wen     = w;
        bus.in_rd      = rd;
        bus.in_result  = res;
        if (w && rd != 5'd0) exp_q.push_back({rd, res});
        ret_exp++;
        step();
    endtask

    task automatic send_load(input logic w, input logic [4:0] rd,
                             input logic [2:0] f3, input logic [1:0] lo);
        bus.in_valid   = 1'b1;
        bus.in_is_load = 1'b1;
        bus.in_wen     = w;
        bus.in_rd      = rd;
        bus.in_funct3  = f3;
        bus.in_addr_lo = lo;
        step();
        bus.in_valid   = 1'b0;
        bus.in_is_load = 1'b0;
    endtask

    task automatic mem_resp(input logic w, input logic [4:0] rd,
                            input logic [31:0] raw, input logic [31:0] val);
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = raw;
        if (w && rd != 5'd0) exp_q.push_back({rd, val});
        ret_exp++;
        step();
        bus.mem_rvalid = 1'b0;
    endtask

    task automatic check_drained(input string name);
        step();
        checks++;
        if (exp_q.size() !== 0) begin
            errors++;
            $display("FAIL %s_missing_write: got %0d pending, required 0",
                     name, exp_q.size());
            exp_q.delete();
        end
        checks++;
        if (bus.retired !== ret_exp) begin
            errors++;
            $display("FAIL %s_retired: got %0d, required %0d",
                     name, bus.retired, ret_exp);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        step();
        step();
        checks++;
        if ({bus.wen, bus.addrW, bus.dataW, bus.load_err} !== 39'd0) begin
            errors++;
            $display("FAIL reset_write_port: got wen=%b rd=%0d data=%h err=%b, required all 0",
                     bus.wen, bus.addrW, bus.dataW, bus.load_err);
        end
        checks++;
        if (bus.retired !== 32'd0) begin
            errors++;
            $display("FAIL reset_retired: got %0d, required 0", bus.retired);
        end
        checks++;
        if (bus.in_ready !== 1'b1 || bus.stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_handshake: got ready=%b stall=%b, required 1 0",
                     bus.in_ready, bus.stall);
        end
        rst_n = 1'b1;
        ret_exp = 32'd0;
        step();
    endtask

    task automatic test_back_to_back();
        send_alu(1'b1, 5'd5, 32'd1);
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ready: got %b, required 1", bus.in_ready);
        end
        send_alu(1'b1, 5'd6, 32'd2);
        send_alu(1'b1, 5'd0, 32'd3);
        bus.in_valid = 1'b0;
        check_drained("b2b");
        checks++;
        if (bus.retired !== 32'd3) begin
            errors++;
            $display("FAIL b2b_retired3: got %0d, required 3", bus.retired);
        end
        send_alu(1'b0, 5'd7, 32'h1111_2222);
        for (int i = 0; i < 10; i++) begin
            send_alu(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                     $urandom);
        end
        bus.in_valid = 1'b0;
        check_drained("random_alu");
    endtask

    task automatic test_lb();
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'hDEAD_BEEF;
        send_load(1'b1, 5'd10, 3'b000, 2'd3);
        bus.mem_rvalid = 1'b0;
        for (int c = 1; c <= 2; c++) begin
            checks++;
            if (bus.stall !== 1'b1 || bus.in_ready !== 1'b0) begin
                errors++;
                $display("FAIL lb_wait_cycle%0d: got stall=%b ready=%b, required 1 0",
                         c, bus.stall, bus.in_ready);
            end
            if (c == 1) step();
        end
        mem_resp(1'b1, 5'd10, 32'h80FF_1234, 32'hFFFF_FF80);
        checks++;
        if (bus.stall !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL lb_back_idle: got stall=%b ready=%b, required 0 1",
                     bus.stall, bus.in_ready);
        end
        check_drained("lb");
    endtask

    task automatic test_lh();
        send_load(1'b1, 5'd11, 3'b101, 2'd2);
        mem_resp(1'b1, 5'd11, 32'h8001_F00F, 32'h0000_8001);
        send_load(1'b1, 5'd12, 3'b001, 2'd0);
        mem_resp(1'b1, 5'd12, 32'h8001_F00F, 32'hFFFF_F00F);
        send_load(1'b1, 5'd13, 3'b100, 2'd1);
        mem_resp(1'b1, 5'd13, 32'h0000_9A00, 32'h0000_009A);
        send_load(1'b1, 5'd14, 3'b011, 2'd3);
        mem_resp(1'b1, 5'd14, 32'hCAFE_F00D, 32'hCAFE_F00D);
        send_load(1'b1, 5'd0, 3'b010, 2'd0);
        mem_resp(1'b1, 5'd0, 32'h1234_5678, 32'h1234_5678);
        check_drained("lh");
    endtask

    task automatic test_timeout();
        int got;
        got = 0;
        send_load(1'b1, 5'd15, 3'b010, 2'd0);
        for (int n = 1; n <= 40; n++) begin
            step();
            if (bus.load_err === 1'b1) begin
                got = n;
                break;
            end
        end
        checks++;
        if (got !== TO) begin
            errors++;
            $display("FAIL timeout_cycles: got err after %0d cycles, required %0d",
                     got, TO);
        end
        checks++;
        if (bus.stall !== 1'b0 || bus.wen !== 1'b0) begin
            errors++;
            $display("FAIL timeout_state: got stall=%b wen=%b, required 0 0",
                     bus.stall, bus.wen);
        end
        step();
        checks++;
        if (bus.load_err !== 1'b0) begin
            errors++;
            $display("FAIL timeout_pulse: got err=%b, required 0", bus.load_err);
        end
        check_drained("timeout");

        send_load(1'b1, 5'd9, 3'b010, 2'd0);
        for (int n = 1; n < TO; n++) step();
        mem_resp(1'b1, 5'd9, 32'h1357_9BDF, 32'h1357_9BDF);
        checks++;
        if (bus.load_err !== 1'b0 || bus.stall !== 1'b0) begin
            errors++;
            $display("FAIL last_cycle_rvalid: got err=%b stall=%b, required 0 0",
                     bus.load_err, bus.stall);
        end
        check_drained("last_cycle");
    endtask

    task automatic test_reset_wait();
        send_load(1'b1, 5'd20, 3'b010, 2'd0);
        step();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.stall !== 1'b0 || bus.in_ready !== 1'b1 ||
            bus.dataW !== 32'd0 || bus.addrW !== 5'd0 ||
            bus.retired !== 32'd0) begin
            errors++;
            $display("FAIL async_reset: got stall=%b ready=%b rd=%0d data=%h ret=%0d, required 0 1 0 0 0",
                     bus.stall, bus.in_ready, bus.addrW, bus.dataW, bus.retired);
        end
        ret_exp = 32'd0;
        exp_q.delete();
        step();
        rst_n = 1'b1;
        step();
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'hFFFF_FFFF;
        step();
        bus.mem_rvalid = 1'b0;
        step();
        checks++;
        if (bus.wen !== 1'b0 || bus.load_err !== 1'b0 ||
            bus.dataW !== 32'd0 || bus.in_ready !== 1'b1 ||
            bus.stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_abandon: got wen=%b err=%b data=%h ready=%b stall=%b, required 0 0 0 1 0",
                     bus.wen, bus.load_err, bus.dataW, bus.in_ready, bus.stall);
        end
        check_drained("reset_wait");
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_lb();
        test_lh();
        test_timeout();
        test_reset_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/writeback_unit.md
WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 Parameter TIMEOUT, default 16, max cycles spent waiting for a load response.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  memory-stage result valid.
REQ-005 in_ready  output  1  unit can accept a result this cycle.
REQ-006 in_wen  input  1  instruction writes a destination register.
REQ-007 in_rd  input  5  destination register index.
REQ-008 in_is_load  input  1  result comes from a memory load.
REQ-009 in_funct3  input  3  load width/sign code (RV32I encoding).
REQ-010 in_addr_lo  input  2  load byte address bits [1:0].
REQ-011 in_result  input  32  ALU/non-load result.
REQ-012 mem_rvalid  input  1  load data valid from data memory.
REQ-013 mem_rdata  input  32  raw 32-bit load word.
REQ-014 wen  output  1  register-file write enable.
REQ-015 addrW  output  5  register-file write index.
REQ-016 dataW  output  32  register-file write data.
REQ-017 stall  output  1  upstream pipeline must hold.
REQ-018 load_err  output  1  one-cycle pulse on load timeout.
REQ-019 retired  output  32  count of committed instructions.

Function
REQ-020 The FSM SHALL have states IDLE and WAIT_MEM; in_ready = (state==IDLE); stall = (state==WAIT_MEM).
REQ-021 A transfer SHALL occur when in_valid and in_ready are both 1 on a rising edge.
REQ-022 A non-load transfer SHALL, on the same edge, register wen = in_wen && (in_rd!=0), addrW = in_rd, dataW = in_result; the state remains IDLE (back-to-back transfers, one per cycle).
REQ-023 A load transfer SHALL capture in_wen, in_rd, in_funct3, and in_addr_lo, drive wen=0, and move to WAIT_MEM.
REQ-024 mem_rvalid SHALL be sampled only in WAIT_MEM; it is ignored in IDLE, including on the load-accept edge.
REQ-025 In WAIT_MEM, on the mem_rvalid edge the unit SHALL register wen = captured wen && rd!=0, addrW = rd, dataW = aligned data, and return to IDLE.
REQ-026 Alignment, funct3 000 LB: byte at addr_lo, sign-extended.
REQ-026a Alignment, 100 LBU: byte at addr_lo, zero-extended.
REQ-026b Alignment, 001 LH / 101 LHU: halfword at addr_lo[1] (addr_lo[0] ignored), sign- or zero-extended respectively.
REQ-026c Alignment, 010 LW and codes 011/110/111: full word; addr_lo ignored.
REQ-027 wen SHALL be high for exactly one cycle per commit, so the register file's mid-cycle (falling-edge) write sees stable addrW/dataW.
REQ-028 In every cycle without a commit, wen SHALL be 0; addrW and dataW hold their last values.
REQ-029 The wait counter SHALL clear on load accept and increment each cycle in WAIT_MEM without mem_rvalid.
REQ-029a If the counter reaches TIMEOUT-1 with no mem_rvalid, the next edge SHALL pulse load_err for 1 cycle, perform no write, and return to IDLE.
REQ-030 mem_rvalid arriving on the final permitted cycle SHALL win over timeout.
REQ-031 retired SHALL increment by 1 on every commit (non-load transfer or load response, including rd=0 or in_wen=0), but not on timeout; it wraps modulo 2^32.
REQ-032 Register x0 SHALL never be written.

Reset
REQ-033 While rst_n=0 the unit SHALL force state=IDLE, wen=0, addrW=0, dataW=0, load_err=0, retired=0, wait counter=0, independent of clk.
REQ-034 Reset asserted in WAIT_MEM SHALL abandon the pending load with no write; a mem_rvalid after reset release, in IDLE, is ignored.

Verification
REQ-035 Non-load sequence: 3 back-to-back transfers to rd=5,6,0 with results 1,2,3 -> wen pulses for rd 5 and 6 only, data 1 and 2, retired=3.
REQ-036 LB at addr_lo=3, mem_rdata=0x80FF_1234, rvalid 2 cycles after accept -> in_ready/stall held for 2 cycles, dataW=0xFFFF_FF80 to rd, retired+1.
REQ-037 LHU at addr_lo=2 and LH at addr_lo=0, mem_rdata=0x8001_F00F -> dataW=0x0000_8001 and 0xFFFF_F00F respectively.
REQ-038 Load with no rvalid -> load_err pulse after 16 WAIT_MEM cycles, no wen, retired unchanged; repeat with rvalid on cycle 16 -> write, no load_err.
REQ-039 rst_n low mid-WAIT_MEM, then rvalid after release -> no write, all outputs at reset values, in_ready=1.
